datapath_controller: RTL

- Multicycle Moore FSM that sequences the processor datapath: fetch, decode, execute, memory and writeback.
- Drives every datapath select and enable (aluControl, mux4En, regpcCont, register enables, regfile write, memory write).
- Decodes the 16-bit instruction fields from memdata and resolves branch and jump conditions from latched flags.
- Sits beside the datapath in the processor top level; one instruction completes per 3–4 cycles.

---
 rtl/datapath_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/datapath_controller.sv
// datapath_controller: multicycle Moore FSM sequencing fetch, decode, execute, memory and writeback
// Ports: clk, reset (async, active-high); opcode/rdest/opext = memdata[15:12]/[11:8]/[7:4];
//        flagZ/flagN latched ALU flags; aluControl, mux4En, regpcCont selects; pcRegEn, srcRegEn,
//        dstRegEn, immRegEn, resultRegEn, regFileEn, irS, memWrite, flagEn enables/strobes;
//        exMemResultEn, signEn, pcRegMuxEn, shiftALUMuxEn, regImmMuxEn mux selects; state for debug.
// Option: define CTRL_ILLEGAL_TRAP_EN to trap undefined encodings in HALT and add output illegal.
module datapath_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   input  logic [3:0] rdest,
   input  logic [3:0] opext,
   input  logic       flagZ,
   input  logic       flagN,
   output logic [3:0] aluControl,
   output logic [1:0] mux4En,
   output logic [1:0] regpcCont,
   output logic       pcRegEn,
   output logic       srcRegEn,
   output logic       dstRegEn,
   output logic       immRegEn,
   output logic       resultRegEn,
   output logic       regFileEn,
   output logic       exMemResultEn,
   output logic       signEn,
   output logic       pcRegMuxEn,
   output logic       shiftALUMuxEn,
   output logic       regImmMuxEn,
   output logic       irS,
   output logic       memWrite,
   output logic       flagEn,
`ifdef CTRL_ILLEGAL_TRAP_EN
   output logic       illegal,
`endif
   output logic [3:0] state
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3, EXEC_SH = 4'd4, WB = 4'd5,
      MEM_LD = 4'd6, LD_WB = 4'd7, MEM_ST = 4'd8, BRANCH = 4'd9, JUMP = 4'd10
`ifdef CTRL_ILLEGAL_TRAP_EN
      , HALT = 4'd11
`endif
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR = 4'b0011,
                          ALU_XOR = 4'b0100, ALU_CMP = 4'b0101, ALU_PASSA = 4'b0110;
`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam state_t UNDEF_NEXT = HALT;
`else
   localparam state_t UNDEF_NEXT = FETCH;
`endif

   state_t     state_q, state_d;
   logic [3:0] op_q, op_d, ext_q, ext_d, cond_q, cond_d, fn, alu_fn;
   logic       taken;

   // Same function-field map serves opext (register forms) and opcode (immediate forms)
   function automatic logic [3:0] alu_of(input logic [3:0] f);
      return f == 4'b0101 ? ALU_ADD : f == 4'b1001 ? ALU_SUB : f == 4'b1011 ? ALU_CMP :
             f == 4'b0001 ? ALU_AND : f == 4'b0010 ? ALU_OR  : f == 4'b0011 ? ALU_XOR : ALU_PASSA;
   endfunction

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      ext_d         = ext_q;
      cond_d        = cond_q;
      aluControl    = ALU_ADD;
      mux4En        = 2'b00;
      regpcCont     = 2'b00;
      pcRegEn       = 1'b0;
      srcRegEn      = 1'b0;
      dstRegEn      = 1'b0;
      immRegEn      = 1'b0;
      resultRegEn   = 1'b0;
      regFileEn     = 1'b0;
      exMemResultEn = 1'b0;
      signEn        = 1'b0;
      pcRegMuxEn    = 1'b0;
      shiftALUMuxEn = 1'b0;
      regImmMuxEn   = 1'b0;
      irS           = 1'b0;
      memWrite      = 1'b0;
      flagEn        = 1'b0;
      fn            = state_q == EXEC_R ? ext_q : op_q;
      alu_fn        = alu_of(fn);
      // Condition comes from the rdest latched at DECODE; flags are the live ones in BRANCH/JUMP
      taken = cond_q == 4'b0000 ? flagZ :
              cond_q == 4'b0001 ? !flagZ :
              cond_q == 4'b0110 ? (!flagZ && !flagN) :
              cond_q == 4'b1100 ? flagN :
              cond_q == 4'b1110;
      case (state_q)
         FETCH: begin
            regpcCont = 2'b01;
            state_d   = DECODE;
         end
         DECODE: begin
            irS      = 1'b1;
            srcRegEn = 1'b1;
            dstRegEn = 1'b1;
            immRegEn = 1'b1;
            mux4En   = 2'b10;
            pcRegEn  = 1'b1;
            // memdata only holds the instruction during DECODE, so keep the fields for later states
            op_d     = opcode;
            ext_d    = opext;
            cond_d   = rdest;
            state_d  = opcode == 4'b0000 ? EXEC_R :
                       opcode inside {4'b0101, 4'b1001, 4'b1011, 4'b1101, 4'b0001, 4'b0010, 4'b0011} ? EXEC_I :
                       opcode == 4'b1000 ? EXEC_SH :
                       opcode == 4'b1100 ? BRANCH :
                       (opcode == 4'b0100 && opext == 4'b0000) ? MEM_LD :
                       (opcode == 4'b0100 && opext == 4'b0100) ? MEM_ST :
                       (opcode == 4'b0100 && opext == 4'b1100) ? JUMP : UNDEF_NEXT;
         end
         EXEC_R, EXEC_I: begin
            aluControl  = alu_fn;
            mux4En      = state_q == EXEC_I ? 2'b01 : 2'b00;
            pcRegMuxEn  = 1'b1;
            resultRegEn = 1'b1;
            flagEn      = alu_fn inside {ALU_ADD, ALU_SUB, ALU_CMP};
            signEn      = state_q == EXEC_I && !(alu_fn inside {ALU_AND, ALU_OR, ALU_XOR});
            state_d     = alu_fn == ALU_CMP ? FETCH : WB;
         end
         EXEC_SH: begin
            shiftALUMuxEn = 1'b1;
            resultRegEn   = 1'b1;
            regImmMuxEn   = ext_q != 4'b0100;
            signEn        = ext_q != 4'b0100;
            state_d       = WB;
         end
         WB: begin
            regFileEn = 1'b1;
            state_d   = FETCH;
         end
         MEM_LD: state_d = LD_WB;
         LD_WB: begin
            exMemResultEn = 1'b1;
            regFileEn     = 1'b1;
            state_d       = FETCH;
         end
         MEM_ST: begin
            memWrite = 1'b1;
            state_d  = FETCH;
         end
         BRANCH: begin
            mux4En  = taken ? 2'b01 : 2'b00;
            signEn  = taken;
            pcRegEn = taken;
            state_d = FETCH;
         end
         JUMP: begin
            aluControl = taken ? ALU_PASSA : ALU_ADD;
            pcRegEn    = taken;
            state_d    = FETCH;
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         HALT: state_d = HALT;
`endif
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         op_q    <= 4'd0;
         ext_q   <= 4'd0;
         cond_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         ext_q   <= ext_d;
         cond_q  <= cond_d;
      end
   end

   assign state = state_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illegal = state_q == HALT;
`endif
endmodule
